// File: rtl/conv_pkg.sv
// conv_pkg: geometry constants and pixel/block types shared by
// image_tiler and conv_pool (4x4 blocks at stride 2 over a raster frame).
package conv_pkg;
   localparam int IMG_W       = 512;
   localparam int IMG_H       = 512;
   localparam int BLK_DIM     = 4;
   localparam int BLK_STRIDE  = 2;
   localparam int BLK_PER_ROW = 255;
   localparam int NUM_BLK     = 65025;
   localparam int ADDR_W      = 16;

   typedef logic [7:0] pixel_t;
   typedef logic [BLK_DIM*BLK_DIM*8-1:0] block_t;

   function automatic int blk_per_dim(input int n);
      return (n - BLK_DIM) / BLK_STRIDE + 1;
   endfunction
endpackage

// File: rtl/tiler_line_buf.sv
// tiler_line_buf: 3-row single-channel line buffer. Presents the column
// at x as {din (row y), y-1, y-2, y-3}; row y-3 is in the low byte.
module tiler_line_buf
   import conv_pkg::*;
#(
   parameter int IMG_W = conv_pkg::IMG_W,
   localparam int XW = $clog2(IMG_W)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [XW-1:0] x,
   input  pixel_t        din,
   output logic [31:0]   col
);
   pixel_t m1_q [IMG_W];
   pixel_t m2_q [IMG_W];
   pixel_t m3_q [IMG_W];

   assign col = {din, m1_q[x], m2_q[x], m3_q[x]};

   // Push each accepted pixel into its column, aging the older rows by one
   always_ff @(posedge clk) begin
      if (we) begin
         m1_q[x] <= din;
         m2_q[x] <= m1_q[x];
         m3_q[x] <= m2_q[x];
      end
   end
endmodule

// File: rtl/image_tiler.sv
// image_tiler: raster RGB stream to 4x4 stride-2 blocks with block index.
// Optional IMAGE_TILER_BLK_CNT_EN adds a blk_count output.
module image_tiler
   import conv_pkg::*;
#(
   parameter int IMG_W = conv_pkg::IMG_W,
   parameter int IMG_H = conv_pkg::IMG_H
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_r,
   input  logic [7:0]        in_g,
   input  logic [7:0]        in_b,
   output logic [127:0]      image_4x4_r,
   output logic [127:0]      image_4x4_g,
   output logic [127:0]      image_4x4_b,
   output logic              output_we,
   output logic [ADDR_W-1:0] output_addr,
   output logic              done
`ifdef IMAGE_TILER_BLK_CNT_EN
   ,
   output logic [ADDR_W-1:0] blk_count
`endif
);
   localparam int XW   = $clog2(IMG_W);
   localparam int YW   = $clog2(IMG_H);
   localparam int BPR  = blk_per_dim(IMG_W);
   localparam int NBLK = BPR * blk_per_dim(IMG_H);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FRAME = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [XW-1:0]     x_q, x_d;
   logic [YW-1:0]     y_q, y_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   block_t            win_q [3];
   block_t            win_d [3];
   block_t            blk_q [3];
   block_t            blk_d [3];
   pixel_t            pix [3];
   logic [31:0]       col [3];
   logic              accept, go, hit, last;

   assign pix[0] = in_r;
   assign pix[1] = in_g;
   assign pix[2] = in_b;

   for (genvar c = 0; c < 3; c++) begin : g_lb
      tiler_line_buf #(.IMG_W(IMG_W)) u_lb (
         .clk (clk),
         .we  (accept),
         .x   (x_q),
         .din (pix[c]),
         .col (col[c])
      );
   end

   assign in_ready = (state_q == S_FRAME);
   assign accept   = in_valid && in_ready;
   assign go       = start && (state_q != S_FRAME);
   assign hit      = accept && (x_q >= XW'(3)) && (y_q >= YW'(3))
                     && x_q[0] && y_q[0];
   assign last     = hit && (cnt_q == ADDR_W'(NBLK - 1));

   assign image_4x4_r = blk_q[0];
   assign image_4x4_g = blk_q[1];
   assign image_4x4_b = blk_q[2];
   assign output_we   = we_q;
   assign output_addr = addr_q;
   assign done        = (state_q == S_DONE) && !we_q;

   // Next-state: raster position, sliding windows and block issue
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      we_d    = hit;
      win_d   = win_q;
      blk_d   = blk_q;
      if (accept) begin
         for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 4; i++) begin
               for (int j = 0; j < 3; j++) begin
                  win_d[c][8*(4*i+j) +: 8] = win_q[c][8*(4*i+j+1) +: 8];
               end
               win_d[c][8*(4*i+3) +: 8] = col[c][8*i +: 8];
            end
         end
         if (x_q == XW'(IMG_W - 1)) begin
            x_d = '0;
            y_d = (y_q == YW'(IMG_H - 1)) ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
      if (hit) begin
         addr_d = cnt_q;
         cnt_d  = cnt_q + 1'b1;
         blk_d  = win_d;
      end
      if (last) state_d = S_DONE;
      if (go) begin
         state_d = S_FRAME;
         x_d     = '0;
         y_d     = '0;
         cnt_d   = '0;
      end
   end

   // State registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         cnt_q   <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         for (int c = 0; c < 3; c++) begin
            win_q[c] <= '0;
            blk_q[c] <= '0;
         end
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         win_q   <= win_d;
         blk_q   <= blk_d;
      end
   end

`ifdef IMAGE_TILER_BLK_CNT_EN
   logic [ADDR_W-1:0] bc_q, bc_d;

   // Count block writes issued in the current frame
   always_comb begin
      bc_d = bc_q;
      if (we_q) bc_d = bc_q + 1'b1;
      if (go) bc_d = '0;
   end

   // Block counter register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) bc_q <= '0;
      else      bc_q <= bc_d;
   end

   assign blk_count = bc_q;
`endif
endmodule

// File: doc/image_tiler.md
IMAGE_TILER -- requirements
Module: image_tiler

Interface
REQ-001 SHALL have parameter IMG_W, default 512, meaning pixels per image row.
REQ-002 SHALL have parameter IMG_H, default 512, meaning image rows per frame.
REQ-003 SHALL have port clk, input, 1 bit: the single clock. All state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle frame start pulse.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1): raster pixel handshake.
REQ-007 SHALL have ports in_r, in_g, in_b, each input, 8 bits: unsigned pixel channels.
REQ-008 SHALL have ports image_4x4_r, image_4x4_g, image_4x4_b, each output, 128 bits: packed 4x4 blocks.
REQ-009 SHALL have port output_we, output, 1 bit: block memory write strobe.
REQ-010 SHALL have port output_addr, output, 16 bits: block index.
REQ-011 SHALL have port done, output, 1 bit: frame complete.

Function
REQ-012 SHALL implement the states IDLE, FRAME and DONE, with the following transitions:
- IDLE->FRAME on start;
- FRAME->DONE when the write for the last block is issued;
- DONE->FRAME on start.
REQ-013 SHALL drive in_ready=1 only in FRAME, and SHALL accept a pixel only on a cycle where in_valid&&in_ready.
REQ-014 SHALL track the column x (0..IMG_W-1) and row y (0..IMG_H-1) of accepted pixels:
- x wraps to 0 after IMG_W-1 and y increments;
- both counters clear on start.
REQ-015 SHALL hold the previous 3 rows per channel in line buffers and a 4x4 window per channel.
REQ-016 SHALL treat the pixel accepted at (x,y) as completing a block when x>=3, y>=3, x odd and y odd. This gives stride 2 and (IMG_W-2)/2=255 blocks per row.
REQ-017 SHALL, in the cycle after a completing handshake, assert output_we for exactly 1 cycle with:
- output_addr=((y-3)/2)*255+(x-3)/2;
- the window for that block on image_4x4_r/g/b.
REQ-018 SHALL place the window pixel at row i, column j (0..3, relative to the block top-left) in bits [8*(4i+j)+7 : 8*(4i+j)].
REQ-019 SHALL keep image_4x4_* and output_addr stable when output_we=0. Their values at those times are don't-care for checking.
REQ-020 SHALL tolerate in_valid gaps of any length without changing results. A stall freezes all counters and windows.
REQ-021 SHALL issue the final write at output_addr=65024, one cycle after pixel (511,511) is accepted. done=1 from the following cycle until start.
REQ-022 SHALL ignore start while in FRAME. A start pulse while in FRAME SHALL NOT restart the frame.

Reset
REQ-023 SHALL, while rst=0, force the state to IDLE and drive in_ready=0, output_we=0, done=0, output_addr=0, image_4x4_*=0, and x=y=0.
REQ-024 SHALL discard any partial frame on a mid-frame reset and resume only on a new start. Line buffer contents need not be cleared.

Configuration
REQ-025 SHALL, with IMAGE_TILER_BLK_CNT_EN defined, add output blk_count (16 bits):
- cleared by reset and by start;
- incremented on each output_we;
- holds 65025 when done=1.
REQ-026 SHALL, without IMAGE_TILER_BLK_CNT_EN, have no blk_count port and no counter logic.

Structure
REQ-027 SHALL place the following in conv_pkg, shared with conv_pool:
- IMG_W, IMG_H;
- BLK_DIM=4, BLK_STRIDE=2, BLK_PER_ROW=255, NUM_BLK=65025;
- ADDR_W=16;
- pixel_t (8-bit) and block_t (128-bit).
REQ-028 SHALL use one sub-module, tiler_line_buf: a 3-row x IMG_W x 8-bit single-channel line buffer. It SHALL be instantiated three times, once per channel.

Verification
REQ-029 SHALL test a ramp frame with r=x[7:0], g=y[7:0], b=0x5A, streamed with no gaps:
- first write is at output_addr=0, one cycle after the 1540th accepted pixel;
- image_4x4_r=0x03020100 repeated 4 times;
- image_4x4_g=128'h03030303_02020202_01010101_00000000;
- image_4x4_b is all 0x5A.
REQ-030 SHALL test the same frame end to end:
- exactly 65025 writes occur, with addresses 0..65024 each written once in ascending order;
- done rises on the cycle after the write to 65024.
REQ-031 SHALL test random in_valid with 50% gaps on a random image: the block memory SHALL match a software model bit-exactly and SHALL be identical to the no-gap run.
REQ-032 SHALL test a reset after 100000 pixels followed by start and a full ramp frame:
- no write occurs during reset;
- the new frame's write at output_addr=0 matches REQ-029.
REQ-033 SHALL test a start pulse mid-frame: it is ignored, and the output is identical to REQ-030. A start in DONE clears done and begins a new frame.
REQ-034 SHALL check, with IMAGE_TILER_BLK_CNT_EN defined, blk_count=65025 at done and blk_count=0 the cycle after start.
